pipe_wb_buf: RTL and testbench

- Handshaked MEM→WB pipeline buffer that queues writeback records {wb_e, data, idx} produced by the MEM stage.
- Presents the records to pipeWB through the buf_avail / buf_re / buf_rack interface.
- Decouples MEM completion timing from register-file write acknowledge latency.
- Small synchronous FIFO with a four-phase handshake FSM on each side.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/hs_fifo_mem.sv | 71 +++++++
 rtl/pipe_wb_buf.sv | 120 ++++++++++++
 tb/tb_pipe_wb_buf.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and handshake state encoding
// for the MEM->WB writeback buffer.
package pipe_pkg;

  localparam int PIPE_DW = 32;
  localparam int PIPE_AW = 5;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

endpackage

// File: rtl/hs_fifo_mem.sv
// Record storage for the writeback buffer:
// register array plus wrap-around pointers and count.
module hs_fifo_mem #(
  parameter  int DEPTH = 4,
  parameter  int RW    = 38,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          we,
  input  logic [RW-1:0] wdata,
  input  logic          re,
  output logic [RW-1:0] rdata,
  output logic          full,
  output logic          avail
);

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (we) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (re) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({we, re})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign avail = (count_q != '0);

endmodule

// File: rtl/pipe_wb_buf.sv
// MEM->WB writeback buffer: four-phase
// handshakes on both sides around a small FIFO.
module pipe_wb_buf
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = PIPE_DW,
  parameter int AW    = PIPE_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_we,
  input  logic          mem_wb_e,
  input  logic [DW-1:0] mem_din,
  input  logic [AW-1:0] mem_idx,
  output logic          mem_wack,
  output logic          full,
  output logic          buf_avail,
  input  logic          buf_re,
  output logic          buf_rack,
  output logic          wb_e,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] idxout,
  input  logic          flush
);

  localparam int RW = 1 + DW + AW;

  hs_state_e wr_st_q, wr_st_d;
  hs_state_e rd_st_q, rd_st_d;
  logic      wr_commit, rd_commit;

  logic [RW-1:0] head;
  logic          wb_e_q, wb_e_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [AW-1:0] idx_q, idx_d;

  hs_fifo_mem #(
    .DEPTH (DEPTH),
    .RW    (RW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .we    (wr_commit),
    .wdata ({mem_wb_e, mem_din, mem_idx}),
    .re    (rd_commit),
    .rdata (head),
    .full  (full),
    .avail (buf_avail)
  );

  // A flushed write still commits here so the
  // requester gets its ack; the FIFO drops it.
  always_comb begin
    wr_st_d   = wr_st_q;
    wr_commit = 1'b0;
    unique case (wr_st_q)
      HS_IDLE: begin
        if (mem_we && !full) begin
          wr_commit = 1'b1;
          wr_st_d   = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!mem_we) wr_st_d = HS_IDLE;
      end
      default: wr_st_d = HS_IDLE;
    endcase
  end

  always_comb begin
    rd_st_d   = rd_st_q;
    rd_commit = 1'b0;
    unique case (rd_st_q)
      HS_IDLE: begin
        if (buf_re && buf_avail && !flush) begin
          rd_commit = 1'b1;
          rd_st_d   = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!buf_re) rd_st_d = HS_IDLE;
      end
      default: rd_st_d = HS_IDLE;
    endcase
  end

  always_comb begin
    wb_e_d = wb_e_q;
    dout_d = dout_q;
    idx_d  = idx_q;
    if (rd_commit) begin
      {wb_e_d, dout_d, idx_d} = head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_st_q <= HS_IDLE;
      rd_st_q <= HS_IDLE;
      wb_e_q  <= 1'b0;
      dout_q  <= '0;
      idx_q   <= '0;
    end else begin
      wr_st_q <= wr_st_d;
      rd_st_q <= rd_st_d;
      wb_e_q  <= wb_e_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
    end
  end

  assign mem_wack = (wr_st_q == HS_ACK);
  assign buf_rack = (rd_st_q == HS_ACK);
  assign wb_e     = wb_e_q;
  assign dout     = dout_q;
  assign idxout   = idx_q;

endmodule

// File: tb/tb_pipe_wb_buf.sv
// Directed bench for pipe_wb_buf: a cycle table
// plus hand sequences for stall, overlap, flush.
module tb_pipe_wb_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we, mem_wb_e;
  logic [31:0] mem_din;
  logic [4:0]  mem_idx;
  logic        mem_wack, full, buf_avail;
  logic        buf_re, buf_rack, wb_e;
  logic [31:0] dout;
  logic [4:0]  idxout;
  logic        flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_wb_buf dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_wb_e  (mem_wb_e),
    .mem_din   (mem_din),
    .mem_idx   (mem_idx),
    .mem_wack  (mem_wack),
    .full      (full),
    .buf_avail (buf_avail),
    .buf_re    (buf_re),
    .buf_rack  (buf_rack),
    .wb_e      (wb_e),
    .dout      (dout),
    .idxout    (idxout),
    .flush     (flush)
  );

  typedef struct {
    logic        we;
    logic        wbe;
    logic [31:0] din;
    logic [4:0]  idx;
    logic        re;
    logic        ewack;
    logic        erack;
    logic        eavail;
    logic        efull;
    logic        ewbe;
    logic [31:0] edout;
    logic [4:0]  eidx;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(
    input logic we, input logic wbe,
    input logic [31:0] din, input logic [4:0] idx,
    input logic re, input logic ewack,
    input logic erack, input logic eavail,
    input logic efull, input logic ewbe,
    input logic [31:0] edout, input logic [4:0] eidx
  );
    vec_t v;
    v.we = we; v.wbe = wbe; v.din = din; v.idx = idx;
    v.re = re; v.ewack = ewack; v.erack = erack;
    v.eavail = eavail; v.efull = efull; v.ewbe = ewbe;
    v.edout = edout; v.eidx = eidx;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wack(input logic v, input string nm);
    int k = 0;
    while (mem_wack !== v && k < 20) begin
      tick();
      k++;
    end
    chk(nm, 64'(mem_wack), 64'(v));
  endtask

  task automatic wait_rack(input logic v, input string nm);
    int k = 0;
    while (buf_rack !== v && k < 20) begin
      tick();
      k++;
    end
    chk(nm, 64'(buf_rack), 64'(v));
  endtask

  task automatic write_rec(input logic wbe,
                           input logic [31:0] d,
                           input logic [4:0] ix);
    @(negedge clk);
    mem_wb_e = wbe;
    mem_din  = d;
    mem_idx  = ix;
    mem_we   = 1'b1;
    wait_wack(1'b1, "wr_ack_rise");
    @(negedge clk);
    mem_we = 1'b0;
    wait_wack(1'b0, "wr_ack_fall");
  endtask

  task automatic read_rec(input logic ewbe,
                          input logic [31:0] ed,
                          input logic [4:0] ei);
    @(negedge clk);
    buf_re = 1'b1;
    wait_rack(1'b1, "rd_ack_rise");
    chk("rd_wb_e", 64'(wb_e), 64'(ewbe));
    chk("rd_dout", 64'(dout), 64'(ed));
    chk("rd_idx", 64'(idxout), 64'(ei));
    @(negedge clk);
    buf_re = 1'b0;
    wait_rack(1'b0, "rd_ack_fall");
  endtask

  task automatic chk_all(input string nm,
                         input logic ew, input logic er,
                         input logic ea, input logic ef,
                         input logic eb,
                         input logic [31:0] ed,
                         input logic [4:0] ei);
    chk({nm, "_wack"}, 64'(mem_wack), 64'(ew));
    chk({nm, "_rack"}, 64'(buf_rack), 64'(er));
    chk({nm, "_avail"}, 64'(buf_avail), 64'(ea));
    chk({nm, "_full"}, 64'(full), 64'(ef));
    chk({nm, "_wbe"}, 64'(wb_e), 64'(eb));
    chk({nm, "_dout"}, 64'(dout), 64'(ed));
    chk({nm, "_idx"}, 64'(idxout), 64'(ei));
  endtask

  initial begin
    vt[0] = mk(1, 1, 32'hAB, 5'd5, 0,
               1, 0, 1, 0, 0, 32'h0, 5'd0);
    vt[1] = mk(0, 0, 32'h0, 5'd0, 0,
               0, 0, 1, 0, 0, 32'h0, 5'd0);
    vt[2] = mk(0, 0, 32'h0, 5'd0, 1,
               0, 1, 0, 0, 1, 32'hAB, 5'd5);
    vt[3] = mk(0, 0, 32'h0, 5'd0, 1,
               0, 1, 0, 0, 1, 32'hAB, 5'd5);
    vt[4] = mk(0, 0, 32'h0, 5'd0, 0,
               0, 0, 0, 0, 1, 32'hAB, 5'd5);
    vt[5] = mk(1, 0, 32'hFFFF_FFFF, 5'd31, 0,
               1, 0, 1, 0, 1, 32'hAB, 5'd5);
    vt[6] = mk(0, 0, 32'h0, 5'd0, 1,
               0, 1, 0, 0, 0, 32'hFFFF_FFFF, 5'd31);
    vt[7] = mk(0, 0, 32'h0, 5'd0, 0,
               0, 0, 0, 0, 0, 32'hFFFF_FFFF, 5'd31);
    vt[8] = mk(0, 0, 32'h0, 5'd0, 1,
               0, 0, 0, 0, 0, 32'hFFFF_FFFF, 5'd31);
    vt[9] = mk(0, 0, 32'h0, 5'd0, 0,
               0, 0, 0, 0, 0, 32'hFFFF_FFFF, 5'd31);

    rst      = 1'b0;
    flush    = 1'b0;
    buf_re   = 1'b0;
    mem_we   = 1'b1;
    mem_wb_e = 1'b1;
    mem_din  = 32'hAB;
    mem_idx  = 5'd5;

    // reset held with a pending write request
    repeat (3) tick();
    chk_all("reset", 0, 0, 0, 0, 0, 32'h0, 5'd0);
    @(negedge clk);
    mem_we = 1'b0;
    rst    = 1'b1;
    tick();
    chk_all("post_reset", 0, 0, 0, 0, 0, 32'h0, 5'd0);

    // cycle table: transfer, no-op record, empty read
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_we   = vt[i].we;
      mem_wb_e = vt[i].wbe;
      mem_din  = vt[i].din;
      mem_idx  = vt[i].idx;
      buf_re   = vt[i].re;
      tick();
      chk_all($sformatf("vec%0d", i),
              vt[i].ewack, vt[i].erack,
              vt[i].eavail, vt[i].efull,
              vt[i].ewbe, vt[i].edout, vt[i].eidx);
    end

    // fill, stall a fifth write, free one slot
    for (int i = 1; i <= 4; i++) begin
      write_rec(1'b1, 32'(i), 5'(i));
    end
    chk("fill_full", 64'(full), 64'(1));
    @(negedge clk);
    mem_wb_e = 1'b1;
    mem_din  = 32'd5;
    mem_idx  = 5'd5;
    mem_we   = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_no_wack", 64'(mem_wack), 64'(0));
    end
    @(negedge clk);
    buf_re = 1'b1;
    tick();
    chk("stall_rd_rack", 64'(buf_rack), 64'(1));
    chk("stall_rd_dout", 64'(dout), 64'(1));
    chk("stall_same_cyc", 64'(mem_wack), 64'(0));
    @(negedge clk);
    buf_re = 1'b0;
    tick();
    chk("stall_commit", 64'(mem_wack), 64'(1));
    chk("stall_refull", 64'(full), 64'(1));
    chk("stall_rack_drop", 64'(buf_rack), 64'(0));
    @(negedge clk);
    mem_we = 1'b0;
    tick();
    chk("stall_wack_drop", 64'(mem_wack), 64'(0));
    for (int i = 2; i <= 5; i++) begin
      read_rec(1'b1, 32'(i), 5'(i));
    end
    chk("wrap_empty", 64'(buf_avail), 64'(0));

    // read and write commit in the same cycle
    write_rec(1'b1, 32'd10, 5'd10);
    write_rec(1'b1, 32'd11, 5'd11);
    @(negedge clk);
    mem_din = 32'd12;
    mem_idx = 5'd12;
    mem_we  = 1'b1;
    buf_re  = 1'b1;
    tick();
    chk("sim_wack", 64'(mem_wack), 64'(1));
    chk("sim_rack", 64'(buf_rack), 64'(1));
    chk("sim_dout", 64'(dout), 64'(10));
    chk("sim_avail", 64'(buf_avail), 64'(1));
    chk("sim_full", 64'(full), 64'(0));
    @(negedge clk);
    mem_we = 1'b0;
    buf_re = 1'b0;
    tick();
    chk("sim_wack_drop", 64'(mem_wack), 64'(0));
    chk("sim_rack_drop", 64'(buf_rack), 64'(0));
    read_rec(1'b1, 32'd11, 5'd11);
    read_rec(1'b1, 32'd12, 5'd12);
    chk("sim_count2", 64'(buf_avail), 64'(0));

    // flush with a concurrent write of data 9
    write_rec(1'b1, 32'd20, 5'd20);
    write_rec(1'b1, 32'd21, 5'd21);
    write_rec(1'b1, 32'd22, 5'd22);
    @(negedge clk);
    mem_din = 32'd9;
    mem_idx = 5'd9;
    mem_we  = 1'b1;
    flush   = 1'b1;
    tick();
    chk("fl_wack", 64'(mem_wack), 64'(1));
    chk("fl_avail", 64'(buf_avail), 64'(0));
    chk("fl_full", 64'(full), 64'(0));
    @(negedge clk);
    flush  = 1'b0;
    mem_we = 1'b0;
    tick();
    chk("fl_wack_drop", 64'(mem_wack), 64'(0));
    chk("fl_still_empty", 64'(buf_avail), 64'(0));
    @(negedge clk);
    buf_re = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_rd_wait", 64'(buf_rack), 64'(0));
    end
    chk("fl_out_hold", 64'(dout), 64'(12));
    write_rec(1'b1, 32'd30, 5'd30);
    wait_rack(1'b1, "fl_rd_rack");
    chk("fl_rd_dout", 64'(dout), 64'(30));
    chk("fl_rd_idx", 64'(idxout), 64'(30));
    @(negedge clk);
    buf_re = 1'b0;
    wait_rack(1'b0, "fl_rd_drop");
    chk("fl_final_empty", 64'(buf_avail), 64'(0));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
